// File: rtl/bisection_pkg.sv
// Shared constants and helpers for the i_ref bisection controller.
// State encodings stay plain 3-bit constants so they match the older logic.
package bisection_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_EVAL = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  typedef enum logic [1:0] {
    ST_NONE      = 2'b00,
    ST_CONV      = 2'b01,
    ST_UNSTABLE  = 2'b10,
    ST_EXHAUSTED = 2'b11
  } status_e;

  // Magnitude of the difference. Callers cast the result to their own width.
  function automatic logic [31:0] abs_diff(input logic [31:0] x, input logic [31:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/bisection_ctrl_if.sv
// Control, measurement-handshake and result signals of the bisection controller.
interface bisection_ctrl_if #(
  parameter int BUS_WIDTH = 10,
  parameter int MAX_ITER  = 16
);
  localparam int IW = $clog2(MAX_ITER + 1);

  logic                 enable;
  logic                 start;
  logic [BUS_WIDTH-1:0] lo_bound;
  logic [BUS_WIDTH-1:0] hi_bound;
  logic [BUS_WIDTH-1:0] q_desired;
  logic [BUS_WIDTH-1:0] q_measured;
  logic                 meas_valid;
  logic                 meas_req;
  logic [BUS_WIDTH-1:0] i_ref;
  logic                 busy;
  logic                 done;
  logic [1:0]           status;
  logic [IW-1:0]        iter_count;

  modport slave (
    input  enable, start, lo_bound, hi_bound, q_desired, q_measured, meas_valid,
    output meas_req, i_ref, busy, done, status, iter_count
  );

  modport master (
    output enable, start, lo_bound, hi_bound, q_desired, q_measured, meas_valid,
    input  meas_req, i_ref, busy, done, status, iter_count
  );

endinterface

// File: rtl/stall_detector.sv
// History of the last DEPTH error magnitudes; flags when the window is full
// and every entry holds the same value.
module stall_detector #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             stalled
);

  localparam int FW = $clog2(DEPTH + 1);
  localparam logic [FW-1:0] FULL = FW'(DEPTH);

  logic [WIDTH-1:0] hist_reg [DEPTH];
  logic [FW-1:0]    fill_reg;
  logic [DEPTH-1:0] match;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      fill_reg <= '0;
      for (int i = 0; i < DEPTH; i++) hist_reg[i] <= '0;
    end else if (push) begin
      hist_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) hist_reg[i] <= hist_reg[i-1];
      if (fill_reg != FULL) fill_reg <= fill_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = (hist_reg[gi] == hist_reg[0]);
    end
  endgenerate

  assign stalled = (fill_reg == FULL) && (&match);

endmodule

// File: rtl/bisection_ctrl.sv
// Bisection search of i_ref within [lo_bound, hi_bound] until the measured Q
// lands within TOL of the target, with iteration limit and stall detection.
module bisection_ctrl
  import bisection_pkg::*;
#(
  parameter int BUS_WIDTH   = 10,
  parameter int TOL         = 1,
  parameter int MAX_ITER    = 16,
  parameter int STALL_COUNT = 3
) (
  input logic         clk,
  input logic         rst,
  bisection_ctrl_if.slave bus
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int EW = BUS_WIDTH + 1;
  localparam logic [IW-1:0] ITER_LIMIT = IW'(MAX_ITER);
  localparam logic [EW-1:0] TOL_W      = EW'(TOL);

  logic [2:0]           state_reg;
  logic [BUS_WIDTH-1:0] a_reg, b_reg, target_reg, q_meas_reg, i_ref_reg;
  logic [EW-1:0]        err_reg;
  logic [IW-1:0]        iter_reg;
  status_e              status_reg;

  logic [EW-1:0]        meas_err;
  logic [EW-1:0]        load_sum, next_sum, span;
  logic [BUS_WIDTH-1:0] new_a, new_b;
  logic [IW-1:0]        iter_next;
  logic                 start_ok, capture, stalled;

  assign start_ok  = (state_reg == S_IDLE) && bus.start && bus.enable;
  assign capture   = (state_reg == S_WAIT) && bus.enable && bus.meas_valid;
  assign meas_err  = EW'(abs_diff(32'(bus.q_measured), 32'(target_reg)));
  assign load_sum  = {1'b0, a_reg} + {1'b0, b_reg};
  assign iter_next = iter_reg + 1'b1;

  // Bracket update applied when an evaluation neither converges nor aborts.
  always_comb begin
    new_a = a_reg;
    new_b = b_reg;
    if (q_meas_reg < target_reg) new_a = i_ref_reg;
    else                         new_b = i_ref_reg;
    span     = {1'b0, new_b} - {1'b0, new_a};
    next_sum = {1'b0, new_a} + {1'b0, new_b};
  end

  // The error is pushed at capture time so the history already holds it in EVAL.
  stall_detector #(
    .WIDTH (EW),
    .DEPTH (STALL_COUNT)
  ) u_stall (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok),
    .push    (capture),
    .din     (meas_err),
    .stalled (stalled)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      target_reg <= '0;
      q_meas_reg <= '0;
      err_reg    <= '0;
      i_ref_reg  <= '0;
      iter_reg   <= '0;
      status_reg <= ST_NONE;
    end else if (state_reg == S_IDLE) begin
      if (start_ok) begin
        a_reg      <= bus.lo_bound;
        b_reg      <= bus.hi_bound;
        target_reg <= bus.q_desired;
        iter_reg   <= '0;
        if (bus.lo_bound > bus.hi_bound) begin
          status_reg <= ST_EXHAUSTED;
          state_reg  <= S_DONE;
        end else begin
          status_reg <= ST_NONE;
          state_reg  <= S_LOAD;
        end
      end
    end else if (!bus.enable) begin
      state_reg  <= S_IDLE;
      status_reg <= ST_NONE;
    end else begin
      case (state_reg)
        S_LOAD: begin
          i_ref_reg <= load_sum[EW-1:1];
          state_reg <= S_REQ;
        end
        S_REQ: state_reg <= S_WAIT;
        S_WAIT: begin
          if (bus.meas_valid) begin
            q_meas_reg <= bus.q_measured;
            err_reg    <= meas_err;
            state_reg  <= S_EVAL;
          end
        end
        S_EVAL: begin
          iter_reg <= iter_next;
          if (err_reg <= TOL_W) begin
            status_reg <= ST_CONV;
            state_reg  <= S_DONE;
          end else if (stalled) begin
            status_reg <= ST_UNSTABLE;
            state_reg  <= S_DONE;
          end else if (iter_next == ITER_LIMIT) begin
            status_reg <= ST_EXHAUSTED;
            state_reg  <= S_DONE;
          end else begin
            a_reg <= new_a;
            b_reg <= new_b;
            if (span <= EW'(1)) begin
              status_reg <= ST_EXHAUSTED;
              state_reg  <= S_DONE;
            end else begin
              i_ref_reg <= next_sum[EW-1:1];
              state_reg <= S_REQ;
            end
          end
        end
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign bus.meas_req   = (state_reg == S_REQ);
  assign bus.busy       = (state_reg != S_IDLE);
  assign bus.done       = (state_reg == S_DONE) && bus.enable;
  assign bus.i_ref      = i_ref_reg;
  assign bus.status     = status_reg;
  assign bus.iter_count = iter_reg;

endmodule

// File: tb/tb_bisection_ctrl.sv
// Directed bench: one controller with default parameters, one with MAX_ITER=4/TOL=0,
// each driven by a simple plant answering meas_req two cycles later.
module tb_bisection_ctrl;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  bisection_ctrl_if #(.BUS_WIDTH(10), .MAX_ITER(16)) bus_a ();
  bisection_ctrl_if #(.BUS_WIDTH(10), .MAX_ITER(4))  bus_b ();

  bisection_ctrl #(.BUS_WIDTH(10), .TOL(1), .MAX_ITER(16), .STALL_COUNT(3)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  bisection_ctrl #(.BUS_WIDTH(10), .TOL(0), .MAX_ITER(4), .STALL_COUNT(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bit stuck_a = 1'b0;
  int req_cnt_a = 0, done_cnt_a = 0, done_cnt_b = 0;
  int seq_a[$];

  // Plant A: linear (q = i_ref) or stuck at 700
  initial begin
    bus_a.meas_valid = 1'b0;
    bus_a.q_measured = '0;
    forever begin
      @(negedge clk);
      if (bus_a.meas_req) begin
        @(negedge clk);
        bus_a.q_measured = stuck_a ? 10'd700 : bus_a.i_ref;
        bus_a.meas_valid = 1'b1;
        @(negedge clk);
        bus_a.meas_valid = 1'b0;
      end
    end
  end

  // Plant B: always linear
  initial begin
    bus_b.meas_valid = 1'b0;
    bus_b.q_measured = '0;
    forever begin
      @(negedge clk);
      if (bus_b.meas_req) begin
        @(negedge clk);
        bus_b.q_measured = bus_b.i_ref;
        bus_b.meas_valid = 1'b1;
        @(negedge clk);
        bus_b.meas_valid = 1'b0;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (bus_a.meas_req) begin
      req_cnt_a++;
      seq_a.push_back(int'(bus_a.i_ref));
    end
    if (bus_a.done) done_cnt_a++;
    if (bus_b.done) done_cnt_b++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  task automatic check_val(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic start_a(input int lo, input int hi, input int qd);
    @(negedge clk);
    bus_a.lo_bound  = 10'(lo);
    bus_a.hi_bound  = 10'(hi);
    bus_a.q_desired = 10'(qd);
    bus_a.start     = 1'b1;
    @(negedge clk);
    bus_a.start     = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int cyc = 0;
    while (!bus_a.done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_done"}, int'(bus_a.done), 1);
    $display("%s: status=%0d iter=%0d i_ref=%0d", tag, bus_a.status, bus_a.iter_count, bus_a.i_ref);
  endtask

  task automatic wait_req_a(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus_a.meas_req) seen++;
    end
    check_val("req_seen", seen, n);
  endtask

  task automatic check_reset_a(input string tag);
    check_val({tag, "_busy"},   int'(bus_a.busy), 0);
    check_val({tag, "_iref"},   int'(bus_a.i_ref), 0);
    check_val({tag, "_status"}, int'(bus_a.status), 0);
    check_val({tag, "_iter"},   int'(bus_a.iter_count), 0);
    check_val({tag, "_done"},   int'(bus_a.done), 0);
    check_val({tag, "_req"},    int'(bus_a.meas_req), 0);
  endtask

  initial begin
    int exp_seq [8] = '{511, 255, 383, 319, 287, 303, 295, 299};
    int r0, d0, cyc;

    rst = 1'b1;
    bus_a.enable = 1'b1; bus_a.start = 1'b0;
    bus_a.lo_bound = '0; bus_a.hi_bound = '0; bus_a.q_desired = '0;
    bus_b.enable = 1'b1; bus_b.start = 1'b0;
    bus_b.lo_bound = '0; bus_b.hi_bound = '0; bus_b.q_desired = '0;
    repeat (3) @(negedge clk);
    check_reset_a("reset");
    rst = 1'b0;

    // Linear plant converges on 299
    seq_a.delete();
    start_a(0, 1023, 300);
    wait_done_a("conv");
    check_val("conv_status", int'(bus_a.status), 1);
    check_val("conv_iter", int'(bus_a.iter_count), 8);
    check_val("conv_iref", int'(bus_a.i_ref), 299);
    check_val("conv_seq_len", seq_a.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < seq_a.size()) check_val($sformatf("conv_seq%0d", i), seq_a[i], exp_seq[i]);
    @(negedge clk);
    check_val("conv_idle_busy", int'(bus_a.busy), 0);
    check_val("conv_status_held", int'(bus_a.status), 1);
    check_val("conv_done_cnt", done_cnt_a, 1);

    // Stuck plant: identical errors three times
    stuck_a = 1'b1;
    start_a(0, 1023, 300);
    wait_done_a("stall");
    check_val("stall_status", int'(bus_a.status), 2);
    check_val("stall_iter", int'(bus_a.iter_count), 3);
    check_val("stall_iref", int'(bus_a.i_ref), 127);
    stuck_a = 1'b0;
    @(negedge clk);

    // Inverted bounds
    r0 = req_cnt_a;
    start_a(600, 100, 300);
    check_val("badb_done", int'(bus_a.done), 1);
    check_val("badb_status", int'(bus_a.status), 3);
    check_val("badb_iter", int'(bus_a.iter_count), 0);
    check_val("badb_iref", int'(bus_a.i_ref), 127);
    @(negedge clk);
    check_val("badb_busy", int'(bus_a.busy), 0);
    check_val("badb_req", req_cnt_a, r0);

    // Abort in WAIT of the third evaluation
    d0 = done_cnt_a;
    start_a(0, 1023, 300);
    wait_req_a(3);
    check_val("abort_req_iref", int'(bus_a.i_ref), 383);
    @(negedge clk);
    bus_a.enable = 1'b0;
    @(negedge clk);
    check_val("abort_busy", int'(bus_a.busy), 0);
    check_val("abort_status", int'(bus_a.status), 0);
    check_val("abort_iref", int'(bus_a.i_ref), 383);
    r0 = req_cnt_a;
    repeat (5) @(negedge clk);
    check_val("abort_no_done", done_cnt_a, d0);
    check_val("abort_no_req", req_cnt_a, r0);
    check_val("abort_iref_hold", int'(bus_a.i_ref), 383);
    bus_a.enable = 1'b1;
    start_a(0, 1023, 300);
    wait_done_a("restart");
    check_val("restart_status", int'(bus_a.status), 1);
    check_val("restart_iter", int'(bus_a.iter_count), 8);
    check_val("restart_iref", int'(bus_a.i_ref), 299);

    // Reset during EVAL of the third evaluation
    start_a(0, 1023, 300);
    wait_req_a(3);
    @(negedge clk);
    @(negedge clk);
    check_val("rst_eval_busy", int'(bus_a.busy), 1);
    check_val("rst_eval_iter", int'(bus_a.iter_count), 2);
    rst = 1'b1;
    @(negedge clk);
    check_reset_a("midrst");
    rst = 1'b0;

    // Starts while busy must not disturb the running search
    d0 = done_cnt_a;
    start_a(0, 1023, 300);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start_a(0, 100, 50);
    end
    wait_done_a("busy_start");
    check_val("busy_start_status", int'(bus_a.status), 1);
    check_val("busy_start_iter", int'(bus_a.iter_count), 8);
    check_val("busy_start_iref", int'(bus_a.i_ref), 299);
    repeat (3) @(negedge clk);
    check_val("busy_start_done_cnt", done_cnt_a - d0, 1);

    // Iteration limit on the MAX_ITER=4, TOL=0 instance
    d0 = done_cnt_b;
    @(negedge clk);
    bus_b.lo_bound = 10'd0; bus_b.hi_bound = 10'd1023; bus_b.q_desired = 10'd300;
    bus_b.start = 1'b1;
    @(negedge clk);
    bus_b.start = 1'b0;
    cyc = 0;
    while (!bus_b.done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check_val("exh_done", int'(bus_b.done), 1);
    $display("exh: status=%0d iter=%0d i_ref=%0d", bus_b.status, bus_b.iter_count, bus_b.i_ref);
    check_val("exh_status", int'(bus_b.status), 3);
    check_val("exh_iter", int'(bus_b.iter_count), 4);
    check_val("exh_iref", int'(bus_b.i_ref), 319);
    repeat (5) @(negedge clk);
    check_val("exh_done_cnt", done_cnt_b - d0, 1);
    check_val("exh_idle_busy", int'(bus_b.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bisection_ctrl.md
Name: bisection_ctrl

Overview:
Parametrised successor to the bias-current bisection loop. Searches i_ref in a programmable [lo_bound, hi_bound] window so that the measured Q matches the desired Q. Uses an explicit FSM with a measurement request/valid handshake, an iteration limit, stall (instability) detection and a status code. Sits between the Q-measurement front end and the i_ref DAC driver in the control path.

Parameters:
BUS_WIDTH, 10, width of the Q and i_ref buses
TOL, 1, convergence tolerance; converged when |q_measured - q_desired| <= TOL
MAX_ITER, 16, maximum evaluations before abort with status EXHAUSTED
STALL_COUNT, 3, number of consecutive identical non-converged errors that declares UNSTABLE (minimum 2)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
enable  in  1  search permitted; deassertion aborts the search
start  in  1  one-cycle pulse that starts a search (accepted only in IDLE with enable=1)
lo_bound  in  BUS_WIDTH  lower i_ref bound, sampled on start
hi_bound  in  BUS_WIDTH  upper i_ref bound, sampled on start
q_desired  in  BUS_WIDTH  target Q, sampled on start
q_measured  in  BUS_WIDTH  measured Q, qualified by meas_valid
meas_valid  in  1  measurement ready; honoured only in WAIT
meas_req  out  1  one-cycle pulse requesting a measurement at the current i_ref
i_ref  out  BUS_WIDTH  registered current midpoint
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a search ends
status  out  2  00 NONE/ABORT, 01 CONVERGED, 10 UNSTABLE, 11 EXHAUSTED; held until the next start
iter_count  out  $clog2(MAX_ITER+1)  evaluations completed in the current or last search

Behaviour:
- Reset: state IDLE; i_ref=0; a=0; b=0; meas_req=0; done=0; busy=0; status=00; iter_count=0; stall history cleared.
- IDLE: start & enable -> LOAD. Latch a=lo_bound, b=hi_bound, target=q_desired. Clear iter_count and history. status=00.
- If lo_bound > hi_bound on start: go directly to DONE with status 11 and iter_count 0. i_ref is unchanged.
- LOAD (1 cycle): i_ref <= (a+b)>>1, with the sum computed in BUS_WIDTH+1 bits (no overflow) -> REQ.
- REQ (1 cycle): meas_req=1 -> WAIT.
- WAIT: hold until meas_valid=1, then capture q_measured -> EVAL. meas_valid in any other state is ignored.
- EVAL (1 cycle):
  - err = |q_measured - target| in signed BUS_WIDTH+1 bits. Increment iter_count.
  - Priority 1: err <= TOL -> status 01, DONE.
  - Priority 2: stall history shows STALL_COUNT equal consecutive errors (including this one) -> status 10, DONE.
  - Priority 3: iter_count == MAX_ITER -> status 11, DONE.
  - Otherwise:
    - q_measured < target -> a = i_ref; else b = i_ref (equality cannot reach here when TOL >= 0).
    - If b - a <= 1 after the update -> status 11, DONE.
    - Else i_ref <= (new a + new b)>>1 -> REQ.
- DONE (1 cycle): done=1 -> IDLE. i_ref holds its last value.
- Abort: enable=0 in any non-IDLE state -> IDLE next cycle, status 00, no done pulse, i_ref held. An outstanding measurement is discarded.
- start while busy is ignored. rst mid-search takes priority over all state transitions.
- Latency: start at cycle 0 -> i_ref valid at cycle 2 -> meas_req at cycle 2. Each evaluation costs 3 cycles plus the measurement wait.

Decomposition:
- Package bisection_pkg holds:
  - FSM state enum (IDLE, LOAD, REQ, WAIT, EVAL, DONE)
  - status codes ST_NONE, ST_CONV, ST_UNSTABLE, ST_EXHAUSTED
  - helper function abs_diff
- Sub-module stall_detector #(WIDTH=BUS_WIDTH+1, DEPTH=STALL_COUNT):
  - shift-register history of err, with clear and push strobes
  - output stalled = all DEPTH entries equal and full

Test Plan:
- Linear plant q_measured=i_ref, lo=0, hi=1023, q_desired=300, TOL=1, meas_valid 2 cycles after meas_req -> i_ref sequence 511,255,383,319,287,303,295,299; done with status 01, iter_count 8, i_ref=299.
- Plant with q_measured stuck at 700, q_desired=300 -> status 10 after 3 evaluations (STALL_COUNT=3), iter_count=3.
- MAX_ITER=4, linear plant, q_desired=300, TOL=0 -> status 11 after 4 evaluations, i_ref=319, a single done pulse.
- start with lo=600, hi=100 -> done pulse 1 cycle later, status 11, iter_count 0, meas_req never asserted.
- enable dropped during WAIT on the 3rd evaluation -> busy low the next cycle, status 00, no done, i_ref holds 383; a second start restarts cleanly.
- rst asserted in EVAL -> next cycle all outputs at reset values; start pulses issued while busy have no effect.
